// File: rtl/tone_pkg.sv
// Shared types and helpers for the tone sequencer and its divider.
package tone_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    GAP  = 2'd2
  } state_t;

  // Counter width able to hold 0..div-1 (at least one bit).
  function automatic int presc_w(input int div);
    return (div <= 1) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/tone_div.sv
// Programmable square-wave divider: period counter plus duty compare with a registered output.
module tone_div
  import tone_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             clear,
  input  logic [CNT_W-1:0] period,
  input  logic [CNT_W-1:0] duty,
  output logic             beep
);

  logic [CNT_W-1:0] cnt_reg;
  logic             beep_reg;
  logic             wrap;

  // Periods 0 and 1 keep the counter parked at zero.
  assign wrap = (period <= CNT_W'(1)) || (cnt_reg >= period - CNT_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg  <= '0;
      beep_reg <= 1'b0;
    end else if (clear) begin
      cnt_reg  <= '0;
      beep_reg <= 1'b0;
    end else if (run) begin
      beep_reg <= (period != '0) && (cnt_reg < duty);
      cnt_reg  <= wrap ? '0 : cnt_reg + CNT_W'(1);
    end else begin
      beep_reg <= 1'b0;
    end
  end

  assign beep = beep_reg;

endmodule

// File: rtl/tone_seq.sv
// Note player: valid/ready note intake, tick-based duration, square-wave beep.
// Optional silent gap after each note is compiled in with TONE_SEQ_GAP_EN.
module tone_seq
  import tone_pkg::*;
#(
  parameter int CNT_W     = 32,
  parameter int DUR_W     = 16,
  parameter int TICK_DIV  = 50000,
  parameter int GAP_TICKS = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             note_valid,
  output logic             note_ready,
  input  logic [CNT_W-1:0] note_period,
  input  logic [CNT_W-1:0] note_duty,
  input  logic [DUR_W-1:0] note_dur,
  input  logic             stop,
  output logic             beep,
  output logic             busy,
  output logic             note_done
);

  localparam int PW = presc_w(TICK_DIV);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] period_reg, duty_reg;
  logic [DUR_W-1:0] dur_reg, dur_cnt_reg;
  logic [PW-1:0]    presc_reg;
  logic             done_reg, done_next;
  logic             accept, tick, play_end, gap_end;
  logic             div_run, div_clear;

  assign note_ready = (state_reg == IDLE) && !stop;
  assign accept     = note_valid && note_ready;
  assign busy       = (state_reg != IDLE);
  assign note_done  = done_reg;
  assign tick       = (presc_reg == PW'(TICK_DIV - 1));
  assign play_end   = (state_reg == PLAY) &&
                      ((dur_reg == '0) || (tick && (dur_cnt_reg == dur_reg - DUR_W'(1))));

`ifdef TONE_SEQ_GAP_EN
  localparam int GW = presc_w(GAP_TICKS + 1);
  logic [GW-1:0] gap_cnt_reg;

  assign gap_end = (state_reg == GAP) && tick && (gap_cnt_reg == GW'(GAP_TICKS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gap_cnt_reg <= '0;
    end else if (state_reg != GAP || state_next != GAP) begin
      gap_cnt_reg <= '0;
    end else if (tick) begin
      gap_cnt_reg <= gap_cnt_reg + GW'(1);
    end
  end
`else
  logic unused_gap;
  assign unused_gap = (GAP_TICKS != 0);
  assign gap_end    = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      done_reg  <= done_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    done_next  = 1'b0;
    if (stop) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE: if (accept) state_next = PLAY;
        PLAY: begin
          if (play_end) begin
            done_next = 1'b1;
`ifdef TONE_SEQ_GAP_EN
            state_next = (GAP_TICKS == 0) ? IDLE : GAP;
`else
            state_next = IDLE;
`endif
          end
        end
        GAP: if (gap_end) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      period_reg <= '0;
      duty_reg   <= '0;
      dur_reg    <= '0;
    end else if (accept) begin
      period_reg <= note_period;
      duty_reg   <= note_duty;
      dur_reg    <= note_dur;
    end
  end

  // Prescaler restarts on every state change so GAP gets a fresh tick grid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_reg <= '0;
    end else if (state_next != state_reg || state_reg == IDLE) begin
      presc_reg <= '0;
    end else begin
      presc_reg <= tick ? '0 : presc_reg + PW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dur_cnt_reg <= '0;
    end else if (state_reg != PLAY || state_next != PLAY) begin
      dur_cnt_reg <= '0;
    end else if (tick) begin
      dur_cnt_reg <= dur_cnt_reg + DUR_W'(1);
    end
  end

  // The divider only advances while PLAY continues, so the exit edge forces beep low.
  assign div_run   = (state_reg == PLAY) && (state_next == PLAY);
  assign div_clear = (state_reg != PLAY);

  tone_div #(
    .CNT_W(CNT_W)
  ) u_div (
    .clk    (clk),
    .rst    (rst),
    .run    (div_run),
    .clear  (div_clear),
    .period (period_reg),
    .duty   (duty_reg),
    .beep   (beep)
  );

endmodule

// File: tb/tb_tone_seq.sv
// Directed self-checking bench for tone_seq (TICK_DIV=4, GAP_TICKS=2).
module tb_tone_seq;

  localparam int CNT_W = 32;
  localparam int DUR_W = 16;

`ifdef TONE_SEQ_GAP_EN
  localparam logic [31:0] T1_BUSY  = 32'b1111111111111111111100;
  localparam logic [31:0] T1_READY = 32'b0000000000000000000011;
  localparam logic [31:0] T2_BUSY  = 32'b111111111111;
  localparam logic [31:0] T3A_BUSY = 32'b111111;
  localparam logic [31:0] T3B_BUSY = 32'b1111111111;
  localparam logic [31:0] T4_BUSY  = 32'b1111;
`else
  localparam logic [31:0] T1_BUSY  = 32'b1111111111110000000000;
  localparam logic [31:0] T1_READY = 32'b0000000000001111111111;
  localparam logic [31:0] T2_BUSY  = 32'b111111110000;
  localparam logic [31:0] T3A_BUSY = 32'b111100;
  localparam logic [31:0] T3B_BUSY = 32'b1111111100;
  localparam logic [31:0] T4_BUSY  = 32'b1000;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             note_valid;
  logic             note_ready;
  logic [CNT_W-1:0] note_period;
  logic [CNT_W-1:0] note_duty;
  logic [DUR_W-1:0] note_dur;
  logic             stop;
  logic             beep;
  logic             busy;
  logic             note_done;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [31:0] tr_beep, tr_busy, tr_done, tr_ready;

  always #5 clk = ~clk;

  tone_seq #(
    .CNT_W    (CNT_W),
    .DUR_W    (DUR_W),
    .TICK_DIV (4),
    .GAP_TICKS(2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .note_valid (note_valid),
    .note_ready (note_ready),
    .note_period(note_period),
    .note_duty  (note_duty),
    .note_dur   (note_dur),
    .stop       (stop),
    .beep       (beep),
    .busy       (busy),
    .note_done  (note_done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called between a negedge and the next posedge; the note is accepted on that posedge.
  task automatic send_note(input logic [CNT_W-1:0] p, input logic [CNT_W-1:0] d,
                           input logic [DUR_W-1:0] n);
    check("ready_before_accept", {31'd0, note_ready}, 32'd1);
    note_period = p;
    note_duty   = d;
    note_dur    = n;
    note_valid  = 1'b1;
    @(posedge clk);
    #1;
    note_valid  = 1'b0;
    note_period = 32'd3;
    note_duty   = 32'd1;
    note_dur    = 16'd1;
    $display("[TB] note sent period=%0d duty=%0d dur=%0d", p, d, n);
  endtask

  task automatic run_trace(input int n);
    tr_beep = '0; tr_busy = '0; tr_done = '0; tr_ready = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      tr_beep  = {tr_beep[30:0], beep};
      tr_busy  = {tr_busy[30:0], busy};
      tr_done  = {tr_done[30:0], note_done};
      tr_ready = {tr_ready[30:0], note_ready};
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("idle_wait", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; note_valid = 1'b0; stop = 1'b0;
    note_period = '0; note_duty = '0; note_dur = '0;
    #2;
    check("rst_beep", {31'd0, beep}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, note_done}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Basic 50% tone, fields scrambled after acceptance
    send_note(32'd10, 32'd5, 16'd3);
    run_trace(22);
    check("t1_beep", tr_beep, 32'b0111110000010000000000);
    check("t1_busy", tr_busy, T1_BUSY);
    check("t1_done", tr_done, 32'b0000000000001000000000);
    check("t1_ready", tr_ready, T1_READY);
    $display("[TB] note 1 traced");

    // Rest note
    wait_idle();
    send_note(32'd0, 32'd3, 16'd2);
    run_trace(12);
    check("t2_beep", tr_beep, 32'd0);
    check("t2_busy", tr_busy, T2_BUSY);
    check("t2_done", tr_done, 32'b000000001000);

    // duty 0 and duty beyond period
    wait_idle();
    send_note(32'd6, 32'd0, 16'd1);
    run_trace(6);
    check("t3a_beep", tr_beep, 32'd0);
    check("t3a_busy", tr_busy, T3A_BUSY);
    check("t3a_done", tr_done, 32'b000010);
    wait_idle();
    send_note(32'd6, 32'd9, 16'd2);
    run_trace(10);
    check("t3b_beep", tr_beep, 32'b0111111100);
    check("t3b_busy", tr_busy, T3B_BUSY);

    // dur 0: one PLAY cycle
    wait_idle();
    send_note(32'd4, 32'd2, 16'd0);
    run_trace(4);
    check("t4_beep", tr_beep, 32'd0);
    check("t4_busy", tr_busy, T4_BUSY);
    check("t4_done", tr_done, 32'b0100);

    // stop mid-note, then immediate new note
    wait_idle();
    send_note(32'd10, 32'd5, 16'd10);
    repeat (5) @(negedge clk);
    check("stop_pre_beep", {31'd0, beep}, 32'd1);
    stop = 1'b1;
    #1;
    check("stop_ready_low", {31'd0, note_ready}, 32'd0);
    @(posedge clk);
    #1;
    stop = 1'b0;
    @(negedge clk);
    check("stop_beep", {31'd0, beep}, 32'd0);
    check("stop_busy", {31'd0, busy}, 32'd0);
    check("stop_done", {31'd0, note_done}, 32'd0);
    send_note(32'd4, 32'd1, 16'd1);
    run_trace(6);
    check("after_stop_beep", tr_beep, 32'b010000);
    check("after_stop_done", tr_done, 32'b000010);
    $display("[TB] stop sequence traced");

    // stop together with valid in IDLE: no acceptance
    wait_idle();
    stop = 1'b1; note_valid = 1'b1; note_period = 32'd4; note_duty = 32'd2; note_dur = 16'd2;
    @(posedge clk);
    #1;
    stop = 1'b0; note_valid = 1'b0;
    @(negedge clk);
    check("stop_valid_busy", {31'd0, busy}, 32'd0);

    // async reset mid-PLAY
    send_note(32'd10, 32'd5, 16'd5);
    repeat (4) @(negedge clk);
    check("pre_rst_beep", {31'd0, beep}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_beep", {31'd0, beep}, 32'd0);
    check("async_rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_trace(6);
    check("post_rst_busy", tr_busy, 32'd0);
    check("post_rst_done", tr_done, 32'd0);
    check("post_rst_ready", {31'd0, note_ready}, 32'd1);
    $display("[TB] reset sequence traced");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
